// File: rtl/mem_arbiter.sv
// Unified word memory with a single port shared by loader, CPU data and CPU fetch.
// Latency: req -> gnt 2 cycles, gnt -> rvalid 1 cycle; at most one access every 2 cycles.
// Backpressure: a requester holds req/addr/data until its gnt; losers simply wait.
//
// Configuration macro: MEM_ARB_RR_EN
//   defined   - data and fetch share round-robin arbitration (loader still absolute priority)
//   undefined - fixed priority loader > data > fetch
//
// Ports:
//   clk, rst                          clock and synchronous active-low reset
//   ld_req/ld_addr/ld_wdata/ld_gnt    write-only loader port
//   d_req/d_we/d_addr/d_wdata/d_gnt   CPU data port (load/store)
//   d_rvalid/d_rdata                  load return, one cycle after d_gnt
//   f_req/f_addr/f_gnt                CPU instruction fetch port (read-only)
//   f_rvalid/f_rdata                  fetch return, one cycle after f_gnt
//   busy                              high while an access is in its GRANT cycle
//   addr_err                          pulses with gnt when the granted address was out of range
module mem_arbiter #(
    parameter int MEMORY_SIZE = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_gnt,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    input  logic                  f_req,
    input  logic [ADDR_WIDTH-1:0] f_addr,
    output logic                  f_gnt,
    output logic                  f_rvalid,
    output logic [DATA_WIDTH-1:0] f_rdata,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int IDX_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0] MEM_SIZE_W = (ADDR_WIDTH + 1)'(MEMORY_SIZE);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        OWN_LD = 2'd0,
        OWN_D  = 2'd1,
        OWN_F  = 2'd2
    } owner_t;

    // FSM state and the latched access
    state_t                  state_q;
    owner_t                  owner_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    // Registered outputs
    logic                    ld_gnt_q;
    logic                    d_gnt_q;
    logic                    f_gnt_q;
    logic                    d_rvalid_q;
    logic                    f_rvalid_q;
    logic [DATA_WIDTH-1:0]   d_rdata_q;
    logic [DATA_WIDTH-1:0]   f_rdata_q;
    logic                    busy_q;
    logic                    addr_err_q;

    // Read word captured in the GRANT cycle, presented one cycle later
    logic                    d_rpend_q;
    logic                    f_rpend_q;
    logic [DATA_WIDTH-1:0]   rbuf_q;

`ifdef MEM_ARB_RR_EN
    // 1 = fetch was the last of data/fetch to be granted, so data wins the next tie
    logic                    last_f_q;
`endif

    logic [DATA_WIDTH-1:0]   mem_q [MEMORY_SIZE];

    // Arbitration (next owner) and access decode
    logic                    win_vld_d;
    owner_t                  win_d;
    logic                    in_range;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   rd_word;

    always_comb begin
        win_vld_d = ld_req | d_req | f_req;
        win_d     = OWN_F;
        if (ld_req) begin
            win_d = OWN_LD;
        end else if (d_req && f_req) begin
`ifdef MEM_ARB_RR_EN
            win_d = last_f_q ? OWN_D : OWN_F;
`else
            win_d = OWN_D;
`endif
        end else if (d_req) begin
            win_d = OWN_D;
        end else begin
            win_d = OWN_F;
        end
    end

    assign in_range = ({1'b0, addr_q} < MEM_SIZE_W);
    assign idx      = addr_q[IDX_W-1:0];
    // Out-of-range reads return zero rather than an aliased word
    assign rd_word  = in_range ? mem_q[idx] : '0;

    // Memory array is never reset; a reset during GRANT suppresses the write.
    always_ff @(posedge clk) begin
        if (rst && (state_q == S_GRANT) && we_q && in_range) begin
            mem_q[idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_LD;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ld_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            f_gnt_q    <= 1'b0;
            d_rvalid_q <= 1'b0;
            f_rvalid_q <= 1'b0;
            d_rdata_q  <= '0;
            f_rdata_q  <= '0;
            busy_q     <= 1'b0;
            addr_err_q <= 1'b0;
            d_rpend_q  <= 1'b0;
            f_rpend_q  <= 1'b0;
            rbuf_q     <= '0;
`ifdef MEM_ARB_RR_EN
            last_f_q   <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low
            ld_gnt_q   <= 1'b0;
            d_gnt_q    <= 1'b0;
            f_gnt_q    <= 1'b0;
            addr_err_q <= 1'b0;
            d_rpend_q  <= 1'b0;
            f_rpend_q  <= 1'b0;

            // Read return from the previous GRANT; rdata only moves with rvalid
            d_rvalid_q <= d_rpend_q;
            f_rvalid_q <= f_rpend_q;
            if (d_rpend_q) begin
                d_rdata_q <= rbuf_q;
            end
            if (f_rpend_q) begin
                f_rdata_q <= rbuf_q;
            end

            case (state_q)
                S_IDLE: begin
                    if (win_vld_d) begin
                        state_q <= S_GRANT;
                        busy_q  <= 1'b1;
                        owner_q <= win_d;
                        case (win_d)
                            OWN_LD: begin
                                addr_q  <= ld_addr;
                                we_q    <= 1'b1;
                                wdata_q <= ld_wdata;
                            end
                            OWN_D: begin
                                addr_q  <= d_addr;
                                we_q    <= d_we;
                                wdata_q <= d_wdata;
                            end
                            default: begin
                                addr_q  <= f_addr;
                                we_q    <= 1'b0;
                                wdata_q <= '0;
                            end
                        endcase
                    end
                end
                S_GRANT: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    addr_err_q <= !in_range;
                    rbuf_q     <= rd_word;
                    case (owner_q)
                        OWN_LD: begin
                            ld_gnt_q <= 1'b1;
                        end
                        OWN_D: begin
                            d_gnt_q   <= 1'b1;
                            d_rpend_q <= !we_q;
`ifdef MEM_ARB_RR_EN
                            last_f_q  <= 1'b0;
`endif
                        end
                        OWN_F: begin
                            f_gnt_q   <= 1'b1;
                            f_rpend_q <= 1'b1;
`ifdef MEM_ARB_RR_EN
                            last_f_q  <= 1'b1;
`endif
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ld_gnt   = ld_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign f_gnt    = f_gnt_q;
    assign d_rvalid = d_rvalid_q;
    assign f_rvalid = f_rvalid_q;
    assign d_rdata  = d_rdata_q;
    assign f_rdata  = f_rdata_q;
    assign busy     = busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized request rounds.
// Expected behaviour comes from a transaction-level model (service order, array, timing rule).
// Inputs are driven 1 time unit after posedge; outputs are sampled at the same point.
module tb_mem_arbiter;

    localparam int MS = 32;
    localparam int AW = 8;
    localparam int DW = 16;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_gnt;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_gnt;
    logic          f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          busy;
    logic          addr_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .MEMORY_SIZE(MS),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_req   (ld_req),
        .ld_addr  (ld_addr),
        .ld_wdata (ld_wdata),
        .ld_gnt   (ld_gnt),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .f_req    (f_req),
        .f_addr   (f_addr),
        .f_gnt    (f_gnt),
        .f_rvalid (f_rvalid),
        .f_rdata  (f_rdata),
        .busy     (busy),
        .addr_err (addr_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DW-1:0] ref_mem [MS];
    bit            ref_last_f = 1'b0;   // last d/f grant went to fetch
    logic [DW-1:0] ref_d_rd = '0;       // last value delivered on d_rdata
    logic [DW-1:0] ref_f_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(MS, 255));
        return AW'($urandom_range(0, MS - 1));
    endfunction

    task automatic idle_inputs();
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        f_req = 1'b0; f_addr = '0;
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_gnts"},    {29'd0, ld_gnt, d_gnt, f_gnt}, 32'd0);
        chk({tag, "_rvalids"}, {30'd0, d_rvalid, f_rvalid}, 32'd0);
        chk({tag, "_d_rdata"}, 32'(d_rdata), 32'd0);
        chk({tag, "_f_rdata"}, 32'(f_rdata), 32'd0);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_addr_err"}, 32'(addr_err), 32'd0);
        rst = 1'b1;
        ref_last_f = 1'b0;
        ref_d_rd   = '0;
        ref_f_rd   = '0;
    endtask

    // One round: the selected requesters raise req together while the arbiter is idle,
    // each holds it until its own gnt. The model derives service order from the priority
    // rule and expects grant k on cycle 2+2k after the request, read data on the next cycle.
    task automatic run_round(input bit u_ld, input bit u_d, input bit u_f, input bit dwe,
                             input logic [AW-1:0] la, input logic [AW-1:0] da,
                             input logic [AW-1:0] fa, input logic [DW-1:0] lw,
                             input logic [DW-1:0] dw);
        int            ord[$];
        int            n;
        int            o;
        int            rv_due;
        int            rv_own;
        logic [DW-1:0] rv_val;
        logic [AW-1:0] a;
        bit            w;
        logic [DW-1:0] wd;
        logic [2:0]    eg;
        bit            ee;
        logic [1:0]    ev;

        if (u_ld) ord.push_back(0);
        if (u_d && u_f) begin
            if (RR && !ref_last_f) begin
                ord.push_back(2); ord.push_back(1);
            end else begin
                ord.push_back(1); ord.push_back(2);
            end
        end else if (u_d) begin
            ord.push_back(1);
        end else if (u_f) begin
            ord.push_back(2);
        end
        n = ord.size();
        if (u_d || u_f) ref_last_f = (ord[n-1] == 2);

        @(posedge clk); #1;
        ld_req = u_ld; ld_addr = la; ld_wdata = lw;
        d_req = u_d; d_we = dwe; d_addr = da; d_wdata = dw;
        f_req = u_f; f_addr = fa;

        rv_due = -1;
        rv_own = 0;
        rv_val = '0;
        for (int c = 1; c <= 2 * n + 2; c++) begin
            @(posedge clk); #1;
            eg = 3'b000;
            ee = 1'b0;
            ev = 2'b00;
            if ((c % 2 == 0) && (c / 2 - 1 < n)) begin
                o  = ord[c / 2 - 1];
                a  = (o == 0) ? la : ((o == 1) ? da : fa);
                w  = (o == 0) ? 1'b1 : ((o == 1) ? dwe : 1'b0);
                wd = (o == 0) ? lw : dw;
                eg = 3'b100 >> o;
                ee = (a >= AW'(MS));
                if (w) begin
                    if (!ee) ref_mem[a[4:0]] = wd;
                end else begin
                    rv_due = c + 1;
                    rv_own = o;
                    rv_val = ee ? '0 : ref_mem[a[4:0]];
                end
                if (o == 0) ld_req = 1'b0;
                if (o == 1) d_req = 1'b0;
                if (o == 2) f_req = 1'b0;
            end
            if (c == rv_due) begin
                ev = (rv_own == 1) ? 2'b10 : 2'b01;
                if (rv_own == 1) ref_d_rd = rv_val;
                else ref_f_rd = rv_val;
            end
            chk("gnt_vec",  {29'd0, ld_gnt, d_gnt, f_gnt}, {29'd0, eg});
            chk("addr_err", 32'(addr_err), 32'(ee));
            chk("rvalid",   {30'd0, d_rvalid, f_rvalid}, {30'd0, ev});
            chk("busy",     32'(busy), 32'((c % 2 == 1) && (c < 2 * n)));
            if (ev[1]) chk("d_rdata", 32'(d_rdata), 32'(rv_val));
            if (ev[0]) chk("f_rdata", 32'(f_rdata), 32'(rv_val));
        end
        chk("d_rdata_hold", 32'(d_rdata), 32'(ref_d_rd));
        chk("f_rdata_hold", 32'(f_rdata), 32'(ref_f_rd));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit            ul;
        bit            ud;
        bit            uf;
        int            sel;

        rst = 1'b0;
        idle_inputs();
        do_reset("reset0");

        // Give every word a known value through the loader
        for (int i = 0; i < MS; i++) begin
            run_round(1'b1, 1'b0, 1'b0, 1'b0, AW'(i), '0, '0, DW'($urandom), '0);
        end

        // Loader write then fetch of the same word
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 8'd3, '0, '0, 16'hA5A5, '0);
        run_round(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 8'd3, '0, '0);
        chk("fetch_a5a5", 32'(f_rdata), 32'h0000_A5A5);

        // Contention between data load and fetch
        run_round(1'b0, 1'b1, 1'b1, 1'b0, '0, 8'd1, 8'd2, '0, '0);

        // Two back-to-back ties: fixed gives d,f,d,f; round-robin gives f,d,f,d
        run_round(1'b0, 1'b1, 1'b1, 1'b0, '0, 8'd4, 8'd5, '0, '0);
        run_round(1'b0, 1'b1, 1'b1, 1'b0, '0, 8'd6, 8'd7, '0, '0);

        // All three at once: loader write then reads of the same word see new data
        run_round(1'b1, 1'b1, 1'b1, 1'b0, 8'd9, 8'd9, 8'd9, 16'h1357, '0);

        // Reset keeps memory contents
        do_reset("reset1");
        run_round(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 8'd3, '0, '0);
        chk("preload_kept", 32'(f_rdata), 32'h0000_A5A5);

        // Out of range store is dropped (no aliasing onto word 8), read returns 0
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 8'd8, '0, '0, 16'h0F0F, '0);
        run_round(1'b0, 1'b1, 1'b0, 1'b1, '0, 8'd40, '0, '0, 16'hBEEF);
        run_round(1'b0, 1'b1, 1'b0, 1'b0, '0, 8'd40, '0, '0, '0);
        run_round(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 8'd8, '0, '0);
        chk("oor_no_alias", 32'(f_rdata), 32'h0000_0F0F);

        // Reset during GRANT of a data store aborts it
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 8'd5, '0, '0, 16'h1234, '0);
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'd5; d_wdata = 16'hDEAD;
        @(posedge clk); #1;
        chk("midgrant_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        d_req = 1'b0;
        @(posedge clk); #1;
        chk("midgrant_no_gnt", {29'd0, ld_gnt, d_gnt, f_gnt}, 32'd0);
        chk("midgrant_idle", 32'(busy), 32'd0);
        rst = 1'b1;
        ref_last_f = 1'b0;
        ref_d_rd   = '0;
        ref_f_rd   = '0;
        @(posedge clk); #1;
        chk("midgrant_late_gnt", {29'd0, ld_gnt, d_gnt, f_gnt}, 32'd0);
        run_round(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 8'd5, '0, '0);
        chk("midgrant_word", 32'(f_rdata), 32'h0000_1234);

        // Randomized rounds
        for (int r = 0; r < 80; r++) begin
            sel = $urandom_range(1, 7);
            ul = (sel & 4) != 0;
            ud = (sel & 2) != 0;
            uf = (sel & 1) != 0;
            run_round(ul, ud, uf, bit'($urandom_range(0, 1)), rand_addr(), rand_addr(),
                      rand_addr(), DW'($urandom), DW'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
